// File: rtl/fb_scan_arbiter.sv
// Framebuffer SRAM arbiter: shares one single-port SRAM between GPU pixel writes and
// row prefetch into a ping-pong line buffer, then scales the buffered row onto the VGA raster.
module fb_scan_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int SCALE  = 4,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic              vga_blank,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [PIX_W-1:0]  gpu_wdata,
    output logic              gpu_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_out,
    output logic              underrun
);

    localparam int SC_LOG = $clog2(SCALE);
    localparam int COL_W  = $clog2(FB_W);

    typedef enum logic {ST_IDLE = 1'b0, ST_FETCH = 1'b1} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_GPU = 1'b1} owner_t;

    state_t             r_state;
    state_t             w_state_nxt;
    owner_t             r_last_owner;
    logic [9:0]         r_y_prev;
    logic [COL_W-1:0]   r_col;
    logic [ADDR_W-1:0]  r_base;
    logic               r_fetch_buf;
    logic               r_disp_sel;
    logic               r_underrun;
    logic               r_cap_valid;
    logic [COL_W-1:0]   r_cap_col;
    logic               r_cap_buf;
    logic [PIX_W-1:0]   r_pix_out;
    logic [PIX_W-1:0]   r_linebuf0 [FB_W];
    logic [PIX_W-1:0]   r_linebuf1 [FB_W];

    logic               w_trig;
    logic [9:0]         w_src_row;
    logic [9:0]         w_next_row;
    logic               w_fetch_trig;
    logic               w_sel_trig;
    logic [9:0]         w_new_row;
    logic               w_new_buf;
    logic               w_fetch_req;
    logic               w_fetch_gnt;
    logic               w_gpu_gnt;
    logic [9:0]         w_src_x;
    logic [PIX_W-1:0]   w_lb_pix;

    assign w_trig     = (vga_y != r_y_prev);
    assign w_src_row  = vga_y >> SC_LOG;
    assign w_next_row = w_src_row + 10'd1;

    // Line-change decode: frame start fetches row 0, every SCALE-th line flips display and prefetches the next row
    always_comb begin
        w_fetch_trig = 1'b0;
        w_sel_trig   = 1'b0;
        w_new_row    = 10'd0;
        w_new_buf    = 1'b0;
        if (w_trig) begin
            if (vga_y == 10'd524) begin
                w_fetch_trig = 1'b1;
                w_new_row    = 10'd0;
                w_new_buf    = 1'b0;
            end else if ((vga_y < 10'd480) && ((vga_y & 10'(SCALE - 1)) == 10'd0)) begin
                w_sel_trig = 1'b1;
                if (w_next_row < 10'(FB_H)) begin
                    w_fetch_trig = 1'b1;
                    w_new_row    = w_next_row;
                    w_new_buf    = w_next_row[0];
                end else begin
                    w_fetch_trig = 1'b0;
                end
            end else begin
                w_fetch_trig = 1'b0;
            end
        end else begin
            w_fetch_trig = 1'b0;
        end
    end

    // A fetch never issues on a trigger clk, so a restarted fetch begins cleanly at column 0
    assign w_fetch_req = (r_state == ST_FETCH) && !w_fetch_trig && !reset;

    // Arbitration and SRAM drive
    always_comb begin
        w_gpu_gnt   = 1'b0;
        w_fetch_gnt = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = {PIX_W{1'b0}};
        if (w_fetch_req) begin
            if (gpu_req && (r_last_owner == OWN_FETCH)) begin
                w_gpu_gnt = 1'b1;
            end else begin
                w_fetch_gnt = 1'b1;
            end
        end else begin
            w_gpu_gnt = gpu_req && !reset;
        end
        if (w_gpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = gpu_addr;
            mem_wdata = gpu_wdata;
        end else if (w_fetch_gnt) begin
            mem_en   = 1'b1;
            mem_we   = 1'b0;
            mem_addr = r_base + ADDR_W'(r_col);
        end else begin
            mem_en = 1'b0;
        end
    end

    assign gpu_gnt = w_gpu_gnt;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_fetch_trig) begin
            w_state_nxt = ST_FETCH;
        end else if (w_fetch_gnt && (r_col == COL_W'(FB_W - 1))) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM, fetch pointer, owner history and sticky underrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWN_FETCH;
            r_y_prev     <= vga_y;
            r_col        <= {COL_W{1'b0}};
            r_base       <= {ADDR_W{1'b0}};
            r_fetch_buf  <= 1'b0;
            r_disp_sel   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_y_prev <= vga_y;
            if (w_gpu_gnt) begin
                r_last_owner <= OWN_GPU;
            end else if (w_fetch_gnt) begin
                r_last_owner <= OWN_FETCH;
            end
            if (w_fetch_trig) begin
                r_col       <= {COL_W{1'b0}};
                r_base      <= ADDR_W'(w_new_row) * ADDR_W'(FB_W);
                r_fetch_buf <= w_new_buf;
            end else if (w_fetch_gnt) begin
                r_col <= r_col + COL_W'(1);
            end
            if (w_sel_trig) begin
                r_disp_sel <= w_src_row[0];
            end
            if (w_fetch_trig && (r_state == ST_FETCH)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Read-return bookkeeping: SRAM data arrives one clk after the strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_valid <= 1'b0;
            r_cap_col   <= {COL_W{1'b0}};
            r_cap_buf   <= 1'b0;
        end else begin
            r_cap_valid <= w_fetch_gnt;
            r_cap_col   <= r_col;
            r_cap_buf   <= r_fetch_buf;
        end
    end

    // Line buffer storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (r_cap_valid) begin
            if (r_cap_buf) begin
                r_linebuf1[r_cap_col] <= mem_rdata;
            end else begin
                r_linebuf0[r_cap_col] <= mem_rdata;
            end
        end
    end

    assign w_src_x = vga_x >> SC_LOG;

    // Display-side line buffer read
    always_comb begin
        w_lb_pix = {PIX_W{1'b0}};
        if (w_src_x < 10'(FB_W)) begin
            if (r_disp_sel) begin
                w_lb_pix = r_linebuf1[w_src_x[COL_W-1:0]];
            end else begin
                w_lb_pix = r_linebuf0[w_src_x[COL_W-1:0]];
            end
        end else begin
            w_lb_pix = {PIX_W{1'b0}};
        end
    end

    // Registered pixel output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_out <= {PIX_W{1'b0}};
        end else begin
            r_pix_out <= vga_blank ? {PIX_W{1'b0}} : w_lb_pix;
        end
    end

    assign pix_out  = r_pix_out;
    assign underrun = r_underrun;

endmodule
